// File: rtl/mips_data_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and constants for the MIPS data bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    // Bridge access sequencer states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } t_bus_state;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;
    localparam logic [3:0] BYTEEN_NONE = 4'b0000;

    // Word accesses only: the two low address bits must be zero
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_data_bus_bridge_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_watchdog
// Description : Access timeout counter. Counts enabled cycles and flags
//               expiry on the TIMEOUT_CYCLES-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    logic [CW-1:0] count_q;

    // Count enabled cycles; hold at the terminal value until cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != C_LAST)) begin
            count_q <= count_q + C_ONE;
        end
    end

    assign expired_o = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mips_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mips_data_bus_bridge
// Description : Bridges the CPU data port onto a wait-stated, pipelined-read
//               memory bus. Stalls the CPU for the duration of each access,
//               returns latched read data, and raises a sticky error flag on
//               misaligned, conflicting or timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_data_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_READDATA   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clock_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    input  logic        bus_readdatavalid,
    output logic        bus_error
);

    t_bus_state  state_q,    state_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        rd_q,       rd_d;
    logic        wr_q,       wr_d;
    logic [31:0] readdata_q, readdata_d;
    logic        error_q,    error_d;
    logic        abort;
    logic        req;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;

    assign req       = cpu_data_read | cpu_data_write;
    assign wd_clear  = (state_q == S_IDLE);
    assign wd_enable = (state_q == S_REQ) || (state_q == S_WAIT_RD);

    mips_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Next-state, datapath next values and CPU enable
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        readdata_d = readdata_q;
        error_d    = error_q;
        abort      = 1'b0;

        // The stall asserts in the very cycle the request appears; reset
        // releases the CPU unconditionally.
        cpu_clock_enable = reset
                         | ((state_q == S_IDLE) & ~req)
                         | (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (is_word_aligned(cpu_data_address[1:0]) &&
                        !(cpu_data_read && cpu_data_write)) begin
                        addr_d  = {cpu_data_address[31:2], 2'b00};
                        wdata_d = cpu_data_writedata;
                        rd_d    = cpu_data_read;
                        wr_d    = cpu_data_write;
                        state_d = S_REQ;
                    end else begin
                        // Rejected without touching the bus
                        error_d    = 1'b1;
                        readdata_d = ERR_READDATA;
                        state_d    = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (!bus_waitrequest) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (wr_q) begin
                        state_d = S_DONE;
                    end else if (bus_readdatavalid) begin
                        // Zero-latency slave: data arrives with the accept
                        readdata_d = bus_readdata;
                        state_d    = S_DONE;
                    end else if (wd_expired) begin
                        abort = 1'b1;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            S_WAIT_RD: begin
                if (bus_readdatavalid) begin
                    readdata_d = bus_readdata;
                    state_d    = S_DONE;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            S_DONE: begin
                // Single commit cycle; a request still present is not re-issued
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            rd_d       = 1'b0;
            wr_d       = 1'b0;
            error_d    = 1'b1;
            readdata_d = ERR_READDATA;
            state_d    = S_DONE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            readdata_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            readdata_q <= readdata_d;
            error_q    <= error_d;
        end
    end

    assign bus_address       = addr_q;
    assign bus_read          = rd_q;
    assign bus_write         = wr_q;
    assign bus_writedata     = wdata_q;
    assign bus_byteenable    = (rd_q | wr_q) ? BYTEEN_WORD : BYTEEN_NONE;
    assign cpu_data_readdata = readdata_q;
    assign bus_error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_data_bus_bridge
// Description : Scoreboard bench for mips_data_bus_bridge. Directed CPU and
//               bus-slave stimulus pushes expected bus accesses and CPU
//               completions; a monitor pops and compares them as they occur.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_data_bus_bridge;

    localparam int          C_TIMEOUT = 8;
    localparam logic [31:0] C_ERR_RD  = 32'h0;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_data_address;
    logic        cpu_data_read;
    logic        cpu_data_write;
    logic [31:0] cpu_data_writedata;
    logic [31:0] cpu_data_readdata;
    logic        cpu_clock_enable;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_readdatavalid;
    logic        bus_error;

    mips_data_bus_bridge #(
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .ERR_READDATA   (C_ERR_RD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_data_address   (cpu_data_address),
        .cpu_data_read      (cpu_data_read),
        .cpu_data_write     (cpu_data_write),
        .cpu_data_writedata (cpu_data_writedata),
        .cpu_data_readdata  (cpu_data_readdata),
        .cpu_clock_enable   (cpu_clock_enable),
        .bus_address        (bus_address),
        .bus_read           (bus_read),
        .bus_write          (bus_write),
        .bus_writedata      (bus_writedata),
        .bus_byteenable     (bus_byteenable),
        .bus_waitrequest    (bus_waitrequest),
        .bus_readdata       (bus_readdata),
        .bus_readdatavalid  (bus_readdatavalid),
        .bus_error          (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        acc;
        int          ncyc;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall;
    } cpu_t;

    bus_t exp_bus[$];
    cpu_t exp_cpu[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within bound at %0t", name, $time);
    endtask

    task automatic push_bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic acc, input int n);
        bus_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.acc = acc; e.ncyc = n;
        exp_bus.push_back(e);
    endtask

    task automatic push_cpu(input logic [31:0] rd, input logic err, input int stall);
        cpu_t e;
        e.rdata = rd; e.err = err; e.stall = stall;
        exp_cpu.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic        strobe_now;
    logic        prev_strobe = 1'b0;
    logic        cap_wr;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_acc;
    int          cap_n   = 0;
    int          stall_n = 0;

    task automatic check_bus();
        bus_t e;
        if (exp_bus.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL bus_unexpected: got access addr %h wr %b, expected none at %0t",
                     cap_addr, cap_wr, $time);
        end else begin
            e = exp_bus.pop_front();
            chk("bus_dir", 32'(cap_wr), 32'(e.wr));
            chk("bus_addr", cap_addr, e.addr);
            if (e.wr) chk("bus_wdata", cap_wdata, e.wdata);
            chk("bus_be", 32'(cap_be), 32'h0000_000F);
            chk("bus_accepted", 32'(cap_acc), 32'(e.acc));
            chk("bus_strobe_cycles", 32'(cap_n), 32'(e.ncyc));
        end
    endtask

    task automatic check_cpu();
        cpu_t e;
        if (exp_cpu.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cpu_unexpected: got completion after %0d stalls, expected none at %0t",
                     stall_n, $time);
        end else begin
            e = exp_cpu.pop_front();
            chk("cpu_readdata", cpu_data_readdata, e.rdata);
            chk("cpu_error", 32'(bus_error), 32'(e.err));
            chk("cpu_stall_cycles", 32'(stall_n), 32'(e.stall));
        end
    endtask

    always @(negedge clk) begin
        strobe_now = bus_read | bus_write;
        if (strobe_now) begin
            if (!prev_strobe) begin
                cap_wr    = bus_write;
                cap_addr  = bus_address;
                cap_wdata = bus_writedata;
                cap_be    = bus_byteenable;
                cap_n     = 0;
            end
            cap_n++;
            cap_acc = !bus_waitrequest;
        end else if (prev_strobe) begin
            check_bus();
        end
        prev_strobe = strobe_now;

        if (reset) begin
            stall_n = 0;
        end else if (!cpu_clock_enable) begin
            stall_n++;
        end else if (stall_n > 0) begin
            check_cpu();
            stall_n = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        cpu_data_read      = rd;
        cpu_data_write     = wr;
        cpu_data_address   = a;
        cpu_data_writedata = d;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (cpu_clock_enable) done = 1'b1;
        end
        if (!done) fail_now("cpu_release");
        @(posedge clk);
        #1;
        cpu_data_read  = 1'b0;
        cpu_data_write = 1'b0;
    endtask

    task automatic slave(input int wait_c, input bit is_rd, input int lat,
                         input logic [31:0] data);
        int n;
        n = 0;
        while (!(bus_read | bus_write) && n < 40) begin
            step();
            n++;
        end
        if (!(bus_read | bus_write)) begin
            fail_now("bus_strobe");
            return;
        end
        for (int i = 0; i < wait_c; i++) begin
            bus_waitrequest = 1'b1;
            step();
        end
        bus_waitrequest = 1'b0;
        if (is_rd && lat == 0) begin
            bus_readdatavalid = 1'b1;
            bus_readdata      = data;
        end
        step();
        bus_readdatavalid = 1'b0;
        if (is_rd && lat > 0) begin
            for (int i = 1; i < lat; i++) step();
            bus_readdatavalid = 1'b1;
            bus_readdata      = data;
            step();
            bus_readdatavalid = 1'b0;
        end
        bus_readdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset              = 1'b1;
        cpu_data_address   = 32'h0;
        cpu_data_read      = 1'b1;   // request during reset must not stall the CPU
        cpu_data_write     = 1'b0;
        cpu_data_writedata = 32'h0;
        bus_waitrequest    = 1'b0;
        bus_readdata       = 32'h0;
        bus_readdatavalid  = 1'b0;
        #12;
        chk("rst_bus_read", 32'(bus_read), 32'h0);
        chk("rst_bus_write", 32'(bus_write), 32'h0);
        chk("rst_byteenable", 32'(bus_byteenable), 32'h0);
        chk("rst_readdata", cpu_data_readdata, 32'h0);
        chk("rst_error", 32'(bus_error), 32'h0);
        chk("rst_ce", 32'(cpu_clock_enable), 32'h1);
        cpu_data_read = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("idle_ce", 32'(cpu_clock_enable), 32'h1);

        // 1: zero-wait write
        push_bus(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 1);
        push_cpu(32'h0, 1'b0, 2);
        fork
            cpu_access(1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D);
            slave(0, 1'b0, 0, 32'h0);
        join
        step();

        // 2: read with three wait states, data two cycles after accept
        push_bus(1'b0, 32'h0000_0040, 32'h0, 1'b1, 4);
        push_cpu(32'h1234_5678, 1'b0, 7);
        fork
            cpu_access(1'b1, 1'b0, 32'h0000_0040, 32'h0);
            slave(3, 1'b1, 2, 32'h1234_5678);
        join
        step();

        // 6: read immediately followed by write
        push_bus(1'b0, 32'h0000_2000, 32'h0, 1'b1, 1);
        push_cpu(32'hA5A5_0001, 1'b0, 3);
        push_bus(1'b1, 32'h0000_2004, 32'h55AA_1234, 1'b1, 1);
        push_cpu(32'hA5A5_0001, 1'b0, 2);
        fork
            begin
                cpu_access(1'b1, 1'b0, 32'h0000_2000, 32'h0);
                cpu_access(1'b0, 1'b1, 32'h0000_2004, 32'h55AA_1234);
            end
            begin
                slave(0, 1'b1, 1, 32'hA5A5_0001);
                slave(0, 1'b0, 0, 32'h0);
            end
        join
        step();

        // Read whose data returns with the accept
        push_bus(1'b0, 32'h0000_3000, 32'h0, 1'b1, 2);
        push_cpu(32'h0F0F_F0F0, 1'b0, 3);
        fork
            cpu_access(1'b1, 1'b0, 32'h0000_3000, 32'h0);
            slave(1, 1'b1, 0, 32'h0F0F_F0F0);
        join
        step();

        // 3: misaligned read, then conflicting read+write
        push_cpu(C_ERR_RD, 1'b1, 1);
        cpu_access(1'b1, 1'b0, 32'h0000_0042, 32'h0);
        step();
        push_cpu(C_ERR_RD, 1'b1, 1);
        cpu_access(1'b1, 1'b1, 32'h0000_0050, 32'h0);
        step();

        // 4: slave never accepts
        push_bus(1'b1, 32'h0000_0080, 32'h0BAD_F00D, 1'b0, C_TIMEOUT);
        push_cpu(C_ERR_RD, 1'b1, C_TIMEOUT + 1);
        bus_waitrequest = 1'b1;
        cpu_access(1'b0, 1'b1, 32'h0000_0080, 32'h0BAD_F00D);
        bus_waitrequest = 1'b0;
        step();

        // 5: reset while waiting for read data
        push_bus(1'b0, 32'h0000_0100, 32'h0, 1'b1, 1);
        cpu_data_read    = 1'b1;
        cpu_data_address = 32'h0000_0100;
        step();                          // S_REQ, accepted this cycle
        chk("t5_strobe", 32'(bus_read), 32'h1);
        step();                          // S_WAIT_RD
        reset         = 1'b1;
        cpu_data_read = 1'b0;
        #1;
        chk("t5_rst_bus_read", 32'(bus_read), 32'h0);
        chk("t5_rst_bus_write", 32'(bus_write), 32'h0);
        chk("t5_rst_ce", 32'(cpu_clock_enable), 32'h1);
        chk("t5_rst_error", 32'(bus_error), 32'h0);
        step();
        reset = 1'b0;
        step();
        bus_readdatavalid = 1'b1;
        bus_readdata      = 32'h7777_7777;
        step();
        bus_readdatavalid = 1'b0;
        bus_readdata      = 32'h0;
        chk("t5_late_ce", 32'(cpu_clock_enable), 32'h1);
        chk("t5_late_readdata", cpu_data_readdata, 32'h0);
        step();
        chk("t5_late_idle", 32'(bus_read | bus_write), 32'h0);

        // Normal operation after reset, two wait states
        push_bus(1'b1, 32'h0000_0010, 32'h1122_3344, 1'b1, 3);
        push_cpu(32'h0, 1'b0, 4);
        fork
            cpu_access(1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344);
            slave(2, 1'b0, 0, 32'h0);
        join

        repeat (4) step();
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
        chk("cpu_queue_empty", 32'(exp_cpu.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
